// File: rtl/arp_pkg.sv
// Shared constants, field offsets, state types and byte-select helpers for the ARP responder.
package arp_pkg;

   localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
   localparam logic [15:0] ARP_HTYPE_ETH = 16'h0001;
   localparam logic [15:0] ARP_PTYPE_IP  = 16'h0800;
   localparam logic [7:0]  ARP_HLEN      = 8'd6;
   localparam logic [7:0]  ARP_PLEN      = 8'd4;
   localparam logic [15:0] ARP_OP_REQ    = 16'h0001;
   localparam logic [15:0] ARP_OP_REPLY  = 16'h0002;

   localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0] SFD_BYTE      = 8'hD5;
   localparam logic [7:0] BCAST_BYTE    = 8'hFF;

   localparam int unsigned PRE_LEN = 8;

   // Byte offsets counted from the first byte after the SFD
   localparam logic [5:0] OFF_SRC       = 6'd6;
   localparam logic [5:0] OFF_ETYPE     = 6'd12;
   localparam logic [5:0] OFF_FIXED_END = 6'd21;
   localparam logic [5:0] OFF_SHA       = 6'd22;
   localparam logic [5:0] OFF_SPA       = 6'd28;
   localparam logic [5:0] OFF_THA       = 6'd32;
   localparam logic [5:0] OFF_TPA       = 6'd38;
   localparam logic [5:0] OFF_LAST      = 6'd41;

   // Ethertype through oper, 10 bytes, for request checking and reply building
   localparam logic [79:0] REQ_FIXED   = {ETH_TYPE_ARP, ARP_HTYPE_ETH, ARP_PTYPE_IP,
                                          ARP_HLEN, ARP_PLEN, ARP_OP_REQ};
   localparam logic [79:0] REPLY_FIXED = {ETH_TYPE_ARP, ARP_HTYPE_ETH, ARP_PTYPE_IP,
                                          ARP_HLEN, ARP_PLEN, ARP_OP_REPLY};

   typedef enum logic [1:0] {RIdle, RPre, RHdr, REnd} rx_state_e;
   typedef enum logic [2:0] {TIdle, TPre, TData, TPad, TFcs, TIfg} tx_state_e;

   function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
      logic [47:0] s;
      s = mac << {idx, 3'b000};
      return s[47:40];
   endfunction

   function automatic logic [7:0] ip_byte(input logic [31:0] ip, input logic [1:0] idx);
      logic [31:0] s;
      s = ip << {idx, 3'b000};
      return s[31:24];
   endfunction

   function automatic logic [7:0] fixed_byte(input logic [79:0] vec, input logic [3:0] idx);
      logic [79:0] s;
      s = vec << {idx, 3'b000};
      return s[79:72];
   endfunction

   function automatic logic [1:0] tx_dbg(input tx_state_e s);
      case (s)
         TIdle:       return 2'd0;
         TPre, TData: return 2'd1;
         TPad, TFcs:  return 2'd2;
         default:     return 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/arp_crc32_d8.sv
// Byte-wide reflected Ethernet CRC-32 (poly 0xEDB88320), register plus look-ahead next value.
module arp_crc32_d8 (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        en_i,
   input  logic        init_i,
   input  logic [7:0]  data_i,
   output logic [31:0] crc_o,
   output logic [31:0] crc_next_o
);

   localparam logic [31:0] POLY = 32'hEDB88320;

   logic [31:0] crc_q;
   logic [31:0] crc_d;

   always_comb begin
      crc_d = crc_q;
      for (int i = 0; i < 8; i++) begin
         if (crc_d[0] ^ data_i[i]) crc_d = {1'b0, crc_d[31:1]} ^ POLY;
         else                      crc_d = {1'b0, crc_d[31:1]};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         crc_q <= 32'hFFFFFFFF;
      end else if (init_i) begin
         crc_q <= 32'hFFFFFFFF;
      end else if (en_i) begin
         crc_q <= crc_d;
      end
   end

   assign crc_o      = crc_q;
   assign crc_next_o = crc_d;

endmodule

// File: rtl/arp_responder.sv
// Qualifies ARP requests for board_ip on GMII receive and answers with a padded reply + FCS,
// sharing the transmit PHY through a tx_req/tx_gnt handshake.
module arp_responder
   import arp_pkg::*;
#(
   parameter int unsigned IFG_CYCLES = 12,
   parameter int unsigned PAD_BYTES  = 18
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  e_rxd,
   input  logic        e_rxdv,
   input  logic [47:0] board_mac,
   input  logic [31:0] board_ip,
   input  logic        tx_gnt,
   output logic        tx_req,
   output logic        e_txen,
   output logic [7:0]  e_txd,
   output logic        e_txer,
   output logic [15:0] reply_count,
   output logic [15:0] drop_count,
   output logic [3:0]  arp_state
);

   rx_state_e   rx_state_q;
   logic [5:0]  rx_cnt_q;
   logic        rxdv_q, qualified_q;
   logic        dst_bc_q, dst_uc_q, dst_bc_d, dst_uc_d, hdr_ok;
   logic [47:0] sha_q;
   logic [31:0] spa_q;

   logic        pending_q, commit, tx_done;
   logic [47:0] req_mac_q;
   logic [31:0] req_ip_q;
   logic [15:0] reply_cnt_q, drop_cnt_q;

   tx_state_e   tx_state_q;
   logic [7:0]  tx_cnt_q;
   logic        e_txen_q;
   logic [7:0]  e_txd_q;
   logic [5:0]  data_idx;
   logic [7:0]  data_byte, fcs_byte;
   logic [1:0]  fcs_idx;
   logic [31:0] crc_cur, crc_next, crc_shift;

   // ---------------- receive qualification ----------------
   always_comb begin
      dst_bc_d = dst_bc_q & (e_rxd == BCAST_BYTE);
      dst_uc_d = dst_uc_q & (e_rxd == mac_byte(board_mac, rx_cnt_q[2:0]));
      hdr_ok   = 1'b1;
      if (rx_cnt_q < OFF_SRC) begin
         hdr_ok = dst_bc_d | dst_uc_d;
      end else if (rx_cnt_q >= OFF_ETYPE && rx_cnt_q <= OFF_FIXED_END) begin
         hdr_ok = (e_rxd == fixed_byte(REQ_FIXED, 4'(rx_cnt_q - OFF_ETYPE)));
      end else if (rx_cnt_q >= OFF_TPA) begin
         hdr_ok = (e_rxd == ip_byte(board_ip, 2'(rx_cnt_q - OFF_TPA)));
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_state_q  <= RIdle;
         rx_cnt_q    <= '0;
         rxdv_q      <= 1'b0;
         qualified_q <= 1'b0;
         dst_bc_q    <= 1'b0;
         dst_uc_q    <= 1'b0;
         sha_q       <= '0;
         spa_q       <= '0;
      end else begin
         rxdv_q <= e_rxdv;
         if (!e_rxdv) begin
            rx_state_q  <= RIdle;
            qualified_q <= 1'b0;
         end else begin
            unique case (rx_state_q)
               RIdle: begin
                  qualified_q <= 1'b0;
                  if (e_rxd == PREAMBLE_BYTE) rx_state_q <= RPre;
               end
               RPre: begin
                  if (e_rxd == SFD_BYTE) begin
                     rx_state_q <= RHdr;
                     rx_cnt_q   <= '0;
                     dst_bc_q   <= 1'b1;
                     dst_uc_q   <= 1'b1;
                  end else if (e_rxd != PREAMBLE_BYTE) begin
                     rx_state_q <= REnd;
                  end
               end
               RHdr: begin
                  dst_bc_q <= dst_bc_d;
                  dst_uc_q <= dst_uc_d;
                  rx_cnt_q <= rx_cnt_q + 6'd1;
                  if (rx_cnt_q >= OFF_SHA && rx_cnt_q < OFF_SPA) sha_q <= {sha_q[39:0], e_rxd};
                  if (rx_cnt_q >= OFF_SPA && rx_cnt_q < OFF_THA) spa_q <= {spa_q[23:0], e_rxd};
                  if (!hdr_ok) begin
                     rx_state_q <= REnd;
                  end else if (rx_cnt_q == OFF_LAST) begin
                     rx_state_q  <= REnd;
                     qualified_q <= 1'b1;
                  end
               end
               REnd: begin
                  rx_state_q <= REnd;
               end
               default: rx_state_q <= RIdle;
            endcase
         end
      end
   end

   // ---------------- commit / ownership ----------------
   assign commit  = rxdv_q & ~e_rxdv & qualified_q;
   assign tx_done = (tx_state_q == TIfg) && (tx_cnt_q == 8'(IFG_CYCLES - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending_q   <= 1'b0;
         req_mac_q   <= '0;
         req_ip_q    <= '0;
         reply_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         if (tx_done) begin
            pending_q   <= 1'b0;
            reply_cnt_q <= reply_cnt_q + 16'd1;
         end
         // A request finishing while a reply is owed or in flight is dropped
         if (commit) begin
            if (!pending_q) begin
               pending_q <= 1'b1;
               req_mac_q <= sha_q;
               req_ip_q  <= spa_q;
            end else begin
               drop_cnt_q <= drop_cnt_q + 16'd1;
            end
         end
      end
   end

   // ---------------- transmit ----------------
   assign data_idx = (tx_state_q == TData) ? tx_cnt_q[5:0] + 6'd1 : 6'd0;
   assign fcs_idx  = tx_cnt_q[1:0] + 2'd1;

   always_comb begin
      data_byte = 8'h00;
      if (data_idx < OFF_SRC)        data_byte = mac_byte(req_mac_q, 3'(data_idx));
      else if (data_idx < OFF_ETYPE) data_byte = mac_byte(board_mac, 3'(data_idx - OFF_SRC));
      else if (data_idx < OFF_SHA)   data_byte = fixed_byte(REPLY_FIXED, 4'(data_idx - OFF_ETYPE));
      else if (data_idx < OFF_SPA)   data_byte = mac_byte(board_mac, 3'(data_idx - OFF_SHA));
      else if (data_idx < OFF_THA)   data_byte = ip_byte(board_ip, 2'(data_idx - OFF_SPA));
      else if (data_idx < OFF_TPA)   data_byte = mac_byte(req_mac_q, 3'(data_idx - OFF_THA));
      else                           data_byte = ip_byte(req_ip_q, 2'(data_idx - OFF_TPA));
      crc_shift = crc_cur >> {fcs_idx, 3'b000};
      fcs_byte  = ~crc_shift[7:0];
   end

   // CRC absorbs the byte currently on the wire for the 60 bytes after the SFD
   arp_crc32_d8 u_crc (
      .clk_i      (clk),
      .rst_ni     (reset_n),
      .en_i       ((tx_state_q == TData) || (tx_state_q == TPad)),
      .init_i     (tx_state_q == TIdle),
      .data_i     (e_txd_q),
      .crc_o      (crc_cur),
      .crc_next_o (crc_next)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_state_q <= TIdle;
         tx_cnt_q   <= '0;
         e_txen_q   <= 1'b0;
         e_txd_q    <= '0;
      end else begin
         unique case (tx_state_q)
            TIdle: begin
               if (pending_q && tx_gnt) begin
                  tx_state_q <= TPre;
                  tx_cnt_q   <= '0;
                  e_txen_q   <= 1'b1;
                  e_txd_q    <= PREAMBLE_BYTE;
               end
            end
            TPre: begin
               if (tx_cnt_q == 8'(PRE_LEN - 1)) begin
                  tx_state_q <= TData;
                  tx_cnt_q   <= '0;
                  e_txd_q    <= data_byte;
               end else begin
                  tx_cnt_q <= tx_cnt_q + 8'd1;
                  e_txd_q  <= (tx_cnt_q == 8'(PRE_LEN - 2)) ? SFD_BYTE : PREAMBLE_BYTE;
               end
            end
            TData: begin
               if (tx_cnt_q == 8'(OFF_LAST)) begin
                  tx_state_q <= TPad;
                  tx_cnt_q   <= '0;
                  e_txd_q    <= 8'h00;
               end else begin
                  tx_cnt_q <= tx_cnt_q + 8'd1;
                  e_txd_q  <= data_byte;
               end
            end
            TPad: begin
               if (tx_cnt_q == 8'(PAD_BYTES - 1)) begin
                  tx_state_q <= TFcs;
                  tx_cnt_q   <= '0;
                  e_txd_q    <= ~crc_next[7:0];
               end else begin
                  tx_cnt_q <= tx_cnt_q + 8'd1;
                  e_txd_q  <= 8'h00;
               end
            end
            TFcs: begin
               if (tx_cnt_q == 8'd3) begin
                  tx_state_q <= TIfg;
                  tx_cnt_q   <= '0;
                  e_txen_q   <= 1'b0;
                  e_txd_q    <= 8'h00;
               end else begin
                  tx_cnt_q <= tx_cnt_q + 8'd1;
                  e_txd_q  <= fcs_byte;
               end
            end
            TIfg: begin
               if (tx_done) begin
                  tx_state_q <= TIdle;
                  tx_cnt_q   <= '0;
               end else begin
                  tx_cnt_q <= tx_cnt_q + 8'd1;
               end
            end
            default: begin
               tx_state_q <= TIdle;
               e_txen_q   <= 1'b0;
               e_txd_q    <= 8'h00;
            end
         endcase
      end
   end

   assign tx_req      = pending_q;
   assign e_txen      = e_txen_q;
   assign e_txd       = e_txd_q;
   assign e_txer      = 1'b0;
   assign reply_count = reply_cnt_q;
   assign drop_count  = drop_cnt_q;
   assign arp_state   = {2'(rx_state_q), tx_dbg(tx_state_q)};

endmodule
